// File: rtl/rpm_averager_pkg.sv
// Shared configuration for the RPM averaging datapath: default widths,
// averaging depth and the seconds-to-minutes scale factor.
package rpm_averager_pkg;

  localparam int CFG_RPM_WIDTH    = 16;
  localparam int CFG_NPOINT_AVG_2 = 2;
  localparam int CFG_NPOINT_AVG   = 1 << CFG_NPOINT_AVG_2;
  localparam int CFG_RPM_X60      = 60;

  // Multiply by 60 using two shifts and a subtract; callers zero-extend first.
  function automatic logic [63:0] times60(input logic [63:0] x);
    return (x << 6) - (x << 2);
  endfunction

endpackage

// File: rtl/rpm_ring_avg.sv
// N-entry sample ring with running sum and saturating fill counter.
// Accepts one sample per cycle; the sum always spans all N slots.
module rpm_ring_avg
  import rpm_averager_pkg::*;
#(
  parameter int W  = CFG_RPM_WIDTH,
  parameter int NP = CFG_NPOINT_AVG_2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            sample_valid_i,
  input  logic [W-1:0]    sample_i,
  output logic [W+NP-1:0] sum_o,
  output logic            full_o
);

  localparam int N  = 1 << NP;
  localparam int SW = W + NP;
  localparam logic [NP:0] FILL_MAX = (NP + 1)'(N);

  logic [W-1:0]  buf_q [N];
  logic [NP-1:0] idx_q, idx_d;
  logic [NP:0]   fill_q, fill_d;
  logic [SW-1:0] sum_q, sum_d;

  always_comb begin
    sum_d  = sum_q;
    idx_d  = idx_q;
    fill_d = fill_q;
    if (sample_valid_i) begin
      // Oldest slot leaves the sum as the new sample enters it.
      sum_d = sum_q - SW'(buf_q[idx_q]) + SW'(sample_i);
      idx_d = idx_q + NP'(1);
      if (fill_q != FILL_MAX) begin
        fill_d = fill_q + (NP + 1)'(1);
      end else begin
        fill_d = fill_q;
      end
    end else begin
      sum_d = sum_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q  <= '0;
      idx_q  <= '0;
      fill_q <= '0;
      for (int i = 0; i < N; i++) begin
        buf_q[i] <= '0;
      end
    end else begin
      sum_q  <= sum_d;
      idx_q  <= idx_d;
      fill_q <= fill_d;
      if (sample_valid_i) begin
        buf_q[idx_q] <= sample_i;
      end
    end
  end

  assign sum_o  = sum_q;
  assign full_o = (fill_q == FILL_MAX);

endmodule

// File: rtl/rpm_averager.sv
// Converts toggle-flagged pulses-per-second samples into an N-point averaged
// RPM with a valid/ready output register and overrun indication.
module rpm_averager
  import rpm_averager_pkg::*;
#(
  parameter int RPM_WIDTH    = CFG_RPM_WIDTH,
  parameter int NPOINT_AVG_2 = CFG_NPOINT_AVG_2,
  parameter int PPR_LOG2     = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [RPM_WIDTH-1:0] pulse_rate,
  input  logic                 pulse_rate_change,
  output logic [RPM_WIDTH+5:0] rpm,
  output logic                 rpm_valid,
  input  logic                 rpm_ready,
  output logic                 rpm_settled,
  output logic                 rpm_overrun
);

  localparam int OW = RPM_WIDTH + 6;
  localparam int SW = RPM_WIDTH + NPOINT_AVG_2;

  logic                 tog_prev_q;
  logic                 s1_valid_q;
  logic [RPM_WIDTH-1:0] s1_sample_q;
  logic                 s2_valid_q;
  logic [SW-1:0]        sum_s;
  logic                 full_s;
  logic [RPM_WIDTH-1:0] avg_s;
  logic [63:0]          x60_s;

  logic [OW-1:0] rpm_q, rpm_d;
  logic          valid_q, valid_d;
  logic          settled_q, settled_d;
  logic          overrun_q, overrun_d;

  // Reset loads the current toggle level so no phantom sample follows it.
  always_ff @(posedge clk) begin
    if (rst) begin
      tog_prev_q  <= pulse_rate_change;
      s1_valid_q  <= 1'b0;
      s1_sample_q <= '0;
      s2_valid_q  <= 1'b0;
    end else begin
      tog_prev_q  <= pulse_rate_change;
      s1_valid_q  <= pulse_rate_change ^ tog_prev_q;
      s1_sample_q <= pulse_rate;
      s2_valid_q  <= s1_valid_q;
    end
  end

  rpm_ring_avg #(
    .W  (RPM_WIDTH),
    .NP (NPOINT_AVG_2)
  ) u_ring (
    .clk            (clk),
    .rst            (rst),
    .sample_valid_i (s1_valid_q),
    .sample_i       (s1_sample_q),
    .sum_o          (sum_s),
    .full_o         (full_s)
  );

  assign avg_s = RPM_WIDTH'(sum_s >> NPOINT_AVG_2);
  assign x60_s = times60(64'(avg_s));

  always_comb begin
    rpm_d     = rpm_q;
    valid_d   = valid_q;
    settled_d = settled_q;
    overrun_d = 1'b0;
    if (s2_valid_q) begin
      rpm_d     = OW'(x60_s >> PPR_LOG2);
      valid_d   = 1'b1;
      settled_d = settled_q | full_s;
      overrun_d = valid_q & ~rpm_ready;
    end else if (valid_q && rpm_ready) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rpm_q     <= '0;
      valid_q   <= 1'b0;
      settled_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      rpm_q     <= rpm_d;
      valid_q   <= valid_d;
      settled_q <= settled_d;
      overrun_q <= overrun_d;
    end
  end

  assign rpm         = rpm_q;
  assign rpm_valid   = valid_q;
  assign rpm_settled = settled_q;
  assign rpm_overrun = overrun_q;

endmodule

// File: tb/tb_rpm_averager.sv
// Directed scoreboard bench for rpm_averager (RPM_WIDTH=16, N=4, PPR_LOG2=1).
module tb_rpm_averager;
  import rpm_averager_pkg::*;

  localparam int W   = 16;
  localparam int NP  = 2;
  localparam int PPR = 1;
  localparam int N   = 1 << NP;

  logic          clk = 1'b0;
  logic          rst;
  logic [W-1:0]  pulse_rate;
  logic          pulse_rate_change;
  logic [W+5:0]  rpm;
  logic          rpm_valid;
  logic          rpm_ready;
  logic          rpm_settled;
  logic          rpm_overrun;

  int vectors     = 0;
  int miscompares = 0;

  longint mbuf [N];
  int     midx;
  int     mfill;
  longint msum;
  longint exp_rpm_q [$];
  bit     exp_set_q [$];

  rpm_averager #(
    .RPM_WIDTH    (W),
    .NPOINT_AVG_2 (NP),
    .PPR_LOG2     (PPR)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .pulse_rate        (pulse_rate),
    .pulse_rate_change (pulse_rate_change),
    .rpm               (rpm),
    .rpm_valid         (rpm_valid),
    .rpm_ready         (rpm_ready),
    .rpm_settled       (rpm_settled),
    .rpm_overrun       (rpm_overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) mbuf[i] = 0;
    midx  = 0;
    mfill = 0;
    msum  = 0;
    exp_rpm_q.delete();
    exp_set_q.delete();
  endtask

  // Drive one new sample and push the result the reference average predicts.
  task automatic send(input int v);
    @(negedge clk);
    pulse_rate        = W'(v);
    pulse_rate_change = ~pulse_rate_change;
    msum       = msum - mbuf[midx] + longint'(v);
    mbuf[midx] = longint'(v);
    midx       = (midx + 1) % N;
    if (mfill < N) mfill++;
    exp_rpm_q.push_back(((msum / N) * CFG_RPM_X60) / (1 << PPR));
    exp_set_q.push_back(mfill == N);
  endtask

  task automatic do_reset(input int cycles);
    @(negedge clk);
    rst = 1'b1;
    repeat (cycles) @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  // Consume results at each negedge where a handshake will occur.
  task automatic drain(input string tag);
    int budget = 20;
    while (exp_rpm_q.size() > 0 && budget > 0) begin
      @(negedge clk);
      budget--;
      if (rpm_valid === 1'b1 && rpm_ready === 1'b1) begin
        check({tag, ".rpm"}, 64'(rpm), 64'(exp_rpm_q.pop_front()));
        check({tag, ".settled"}, 64'(rpm_settled), 64'(exp_set_q.pop_front()));
      end
    end
    check({tag, ".timeout"}, 64'(exp_rpm_q.size()), 64'(0));
    exp_rpm_q.delete();
    exp_set_q.delete();
    @(negedge clk);
    check({tag, ".idle"}, 64'(rpm_valid), 64'(0));
  endtask

  initial begin
    bit seen_valid;
    rst               = 1'b1;
    pulse_rate        = '0;
    pulse_rate_change = 1'b0;
    rpm_ready         = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);
    check("reset.rpm", 64'(rpm), 64'(0));
    check("reset.valid", 64'(rpm_valid), 64'(0));
    check("reset.settled", 64'(rpm_settled), 64'(0));
    check("reset.overrun", 64'(rpm_overrun), 64'(0));
    rst = 1'b0;
    model_reset();

    // Warm-up ramp 750/1500/2250/3000, then wrap with 200.
    for (int i = 0; i < 4; i++) begin
      send(100);
      drain("ramp");
    end
    send(200);
    drain("wrap");

    // Overrun with consumer stalled.
    do_reset(2);
    rpm_ready = 1'b0;
    send(100);
    repeat (3) @(negedge clk);
    check("ovr.first_rpm", 64'(rpm), 64'(750));
    check("ovr.first_valid", 64'(rpm_valid), 64'(1));
    check("ovr.first_overrun", 64'(rpm_overrun), 64'(0));
    send(100);
    repeat (3) @(negedge clk);
    check("ovr.pulse", 64'(rpm_overrun), 64'(1));
    check("ovr.rpm", 64'(rpm), 64'(1500));
    check("ovr.valid", 64'(rpm_valid), 64'(1));
    @(negedge clk);
    check("ovr.pulse_end", 64'(rpm_overrun), 64'(0));
    repeat (5) @(negedge clk);
    check("ovr.hold_rpm", 64'(rpm), 64'(1500));
    check("ovr.hold_valid", 64'(rpm_valid), 64'(1));
    rpm_ready = 1'b1;
    @(negedge clk);
    check("ovr.consumed", 64'(rpm_valid), 64'(0));
    exp_rpm_q.delete();
    exp_set_q.delete();

    // Full-scale input must not truncate.
    do_reset(2);
    for (int i = 0; i < 4; i++) begin
      send(65535);
      drain("max");
    end
    check("max.settled", 64'(rpm_settled), 64'(1));
    check("max.rpm", 64'(rpm), 64'(1966050));

    // Reset with toggle held high: no spurious sample afterwards.
    @(negedge clk);
    pulse_rate_change = 1'b1;
    do_reset(3);
    seen_valid = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (rpm_valid !== 1'b0) seen_valid = 1'b1;
    end
    check("quiet.valid", 64'(seen_valid), 64'(0));

    // Mid-warm-up reset, including a sample in flight when reset hits.
    send(100);
    drain("pre");
    send(100);
    drain("pre");
    send(500);
    do_reset(1);
    send(100);
    drain("post");
    check("post.rpm", 64'(rpm), 64'(750));
    check("post.settled", 64'(rpm_settled), 64'(0));

    // Back-to-back toggles give results on consecutive cycles.
    do_reset(2);
    send(40);
    send(80);
    drain("b2b");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
